// File: rtl/neuraedge_noc_pkg.sv
// rtl/neuraedge_noc_pkg.sv - shared NoC arbiter state type and flit-width default
package neuraedge_noc_pkg;

  localparam int NOC_FLIT_WIDTH_DEF = 64;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/noc_rr_pick.sv
// rtl/noc_rr_pick.sv - combinational rotate-priority pick: first request at or after ptr_in
module noc_rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_in,
  input  logic [IDW-1:0]     ptr_in,
  output logic [IDW-1:0]     idx_out,
  output logic               any_out
);

  int w_j;

  // Scan from the farthest candidate back toward ptr_in so the nearest hit wins.
  always_comb begin
    idx_out = '0;
    any_out = |req_in;
    w_j     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_j = int'(ptr_in) + k;
      if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
      if (req_in[w_j]) idx_out = IDW'(w_j);
    end
  end

endmodule

// File: rtl/noc_ext_arbiter.sv
// rtl/noc_ext_arbiter.sv - packet-granular round-robin arbiter for the external NoC ingress port
// Optional stall watchdog compiled in with NOC_ARB_WDOG_EN.
module noc_ext_arbiter
  import neuraedge_noc_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int NOC_FLIT_WIDTH = NOC_FLIT_WIDTH_DEF,
  parameter int WDOG_CYCLES    = 1024,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ*NOC_FLIT_WIDTH-1:0] req_flit_in,
  input  logic [NUM_REQ-1:0]                req_valid_in,
  input  logic [NUM_REQ-1:0]                req_last_in,
  output logic [NUM_REQ-1:0]                req_ready_out,
  output logic [NOC_FLIT_WIDTH-1:0]         ext_flit_out,
  output logic                              ext_valid_out,
  input  logic                              ext_ready_in,
  output logic [IDW-1:0]                    grant_id_out,
  output logic                              busy_out,
  output logic                              wdog_abort_out
);

  arb_state_t                r_state, w_state_nxt;
  logic [IDW-1:0]            r_grant, r_rr_ptr, w_pick_idx, w_grant_inc;
  logic                      w_pick_any;
  logic [NUM_REQ-1:0]        w_drop, w_ready, w_eligible;
  logic                      w_accept, w_accept_last, w_wdog_fire;
  logic                      r_out_vld;
  logic [NOC_FLIT_WIDTH-1:0] r_out_flit, w_sel_flit;

  assign w_eligible  = req_valid_in & ~w_drop;
  assign w_sel_flit  = req_flit_in[int'(r_grant)*NOC_FLIT_WIDTH +: NOC_FLIT_WIDTH];
  assign w_grant_inc = (r_grant == IDW'(NUM_REQ - 1)) ? '0 : r_grant + IDW'(1);

  noc_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_in  (w_eligible),
    .ptr_in  (r_rr_ptr),
    .idx_out (w_pick_idx),
    .any_out (w_pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ARB_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Drop-flagged requesters are always drained, whatever the arbiter state.
  always_comb begin
    w_state_nxt   = r_state;
    w_ready       = w_drop;
    w_accept      = 1'b0;
    w_accept_last = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_any) w_state_nxt = ARB_LOCKED;
      end
      ARB_LOCKED: begin
        w_ready[r_grant] = !r_out_vld || ext_ready_in;
        w_accept         = req_valid_in[r_grant] && w_ready[r_grant];
        w_accept_last    = w_accept && req_last_in[r_grant];
        if (w_accept_last || w_wdog_fire) w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // A load wins over an ext transfer, so the register is replaced without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_out_vld  <= 1'b0;
      r_out_flit <= '0;
    end else begin
      if (r_state == ARB_IDLE && w_pick_any) r_grant <= w_pick_idx;
      if (w_accept_last || w_wdog_fire)      r_rr_ptr <= w_grant_inc;
      if (w_accept) begin
        r_out_vld  <= 1'b1;
        r_out_flit <= w_sel_flit;
      end else if (ext_ready_in) begin
        r_out_vld  <= 1'b0;
      end
    end
  end

`ifdef NOC_ARB_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES);

  logic [CW-1:0]      r_wdog_cnt;
  logic [NUM_REQ-1:0] r_drop, w_drop_done;
  logic               r_wdog_abort;

  assign w_wdog_fire = (r_state == ARB_LOCKED) && !req_valid_in[r_grant] &&
                       (r_wdog_cnt == CW'(WDOG_CYCLES - 1));
  assign w_drop_done = r_drop & req_valid_in & req_last_in;

  // Only requester-side stalls count; ext backpressure leaves valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog_cnt   <= '0;
      r_drop       <= '0;
      r_wdog_abort <= 1'b0;
    end else begin
      if (r_state != ARB_LOCKED || w_accept || w_wdog_fire) r_wdog_cnt <= '0;
      else if (!req_valid_in[r_grant])                      r_wdog_cnt <= r_wdog_cnt + CW'(1);
      r_drop       <= (r_drop & ~w_drop_done) |
                      (w_wdog_fire ? (NUM_REQ'(1) << r_grant) : '0);
      r_wdog_abort <= w_wdog_fire;
    end
  end

  assign w_drop         = r_drop;
  assign wdog_abort_out = r_wdog_abort;
`else
  assign w_drop         = '0;
  assign w_wdog_fire    = 1'b0;
  assign wdog_abort_out = 1'b0;
`endif

  assign req_ready_out = w_ready;
  assign ext_flit_out  = r_out_flit;
  assign ext_valid_out = r_out_vld;
  assign grant_id_out  = r_grant;
  assign busy_out      = (r_state == ARB_LOCKED);

endmodule

// File: tb/tb_noc_ext_arbiter.sv
// tb/tb_noc_ext_arbiter.sv - directed self-checking bench for noc_ext_arbiter
module tb_noc_ext_arbiter;

  localparam int NR = 4;
  localparam int W  = 16;
  localparam int WD = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR*W-1:0] req_flit_in = '0;
  logic [NR-1:0]   req_valid_in = '0;
  logic [NR-1:0]   req_last_in = '0;
  logic [NR-1:0]   req_ready_out;
  logic [W-1:0]    ext_flit_out;
  logic            ext_valid_out;
  logic            ext_ready_in = 1'b1;
  logic [1:0]      grant_id_out;
  logic            busy_out;
  logic            wdog_abort_out;

  noc_ext_arbiter #(.NUM_REQ(NR), .NOC_FLIT_WIDTH(W), .WDOG_CYCLES(WD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_flit_in    (req_flit_in),
    .req_valid_in   (req_valid_in),
    .req_last_in    (req_last_in),
    .req_ready_out  (req_ready_out),
    .ext_flit_out   (ext_flit_out),
    .ext_valid_out  (ext_valid_out),
    .ext_ready_in   (ext_ready_in),
    .grant_id_out   (grant_id_out),
    .busy_out       (busy_out),
    .wdog_abort_out (wdog_abort_out)
  );

  always #5 clk = ~clk;

  int           n_vec = 0;
  int           n_bad = 0;
  int           cyc = 0;
  logic [W:0]   rq[NR][$];
  bit           hold[NR];
  logic [W-1:0] obs_f[$];
  int           obs_c[$];
  logic [NR-1:0] s_ready;
  logic         s_ev, s_busy, s_abort;
  logic [W-1:0] s_flit;
  logic [1:0]   s_grant;

  task automatic push(input int r, input logic [W-1:0] f, input bit last);
    rq[r].push_back({last, f});
  endtask

  task automatic start_test();
    cyc = 0;
    obs_f.delete();
    obs_c.delete();
  endtask

  // One clock: drive queue heads, sample mid-cycle, pop on handshake.
  task automatic tick();
    logic [NR-1:0] acc;
    logic          ex;
    logic [W:0]    hd;
    for (int i = 0; i < NR; i++) begin
      if (rq[i].size() > 0 && !hold[i]) begin
        hd = rq[i][0];
        req_valid_in[i]        = 1'b1;
        req_flit_in[i*W +: W]  = hd[W-1:0];
        req_last_in[i]         = hd[W];
      end else begin
        req_valid_in[i]        = 1'b0;
        req_flit_in[i*W +: W]  = '0;
        req_last_in[i]         = 1'b0;
      end
    end
    @(negedge clk);
    s_ready = req_ready_out;
    s_ev    = ext_valid_out;
    s_flit  = ext_flit_out;
    s_busy  = busy_out;
    s_grant = grant_id_out;
    s_abort = wdog_abort_out;
    acc     = req_valid_in & req_ready_out;
    ex      = ext_valid_out && ext_ready_in;
    if (ex) begin
      obs_f.push_back(ext_flit_out);
      obs_c.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NR; i++)
      if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    ext_ready_in = 1'b1;
    req_valid_in = '0;
    req_last_in  = '0;
    req_flit_in  = '0;
    for (int i = 0; i < NR; i++) begin
      rq[i].delete();
      hold[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    start_test();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (ext_valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_ext_valid: got %b want 0", ext_valid_out); end
    n_vec++; if (ext_flit_out !== '0) begin n_bad++; $display("FAIL reset_ext_flit: got %h want 0", ext_flit_out); end
    n_vec++; if (req_ready_out !== '0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", req_ready_out); end
    n_vec++; if (grant_id_out !== '0) begin n_bad++; $display("FAIL reset_grant: got %0d want 0", grant_id_out); end
    n_vec++; if (busy_out !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_out); end
    n_vec++; if (wdog_abort_out !== 1'b0) begin n_bad++; $display("FAIL reset_abort: got %b want 0", wdog_abort_out); end
    reset_dut();
    tick();
    n_vec++; if (s_busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", s_busy); end
  endtask

  task automatic test_single_packet();
    logic [W-1:0] ex_f[3] = '{16'hA001, 16'hA002, 16'hA003};
    int           ex_c[3] = '{2, 3, 4};
    start_test();
    push(1, 16'hA001, 1'b0);
    push(1, 16'hA002, 1'b0);
    push(1, 16'hA003, 1'b1);
    repeat (6) tick();
    n_vec++; if (obs_f.size() != 3) begin n_bad++; $display("FAIL single_count: got %0d want 3", obs_f.size()); end
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (k >= obs_f.size()) begin n_bad++; $display("FAIL single_flit%0d: got none want %h@%0d", k, ex_f[k], ex_c[k]); end
      else if (obs_f[k] !== ex_f[k] || obs_c[k] != ex_c[k]) begin
        n_bad++; $display("FAIL single_flit%0d: got %h@%0d want %h@%0d", k, obs_f[k], obs_c[k], ex_f[k], ex_c[k]);
      end
    end
    n_vec++; if (s_grant !== 2'd1) begin n_bad++; $display("FAIL single_grant: got %0d want 1", s_grant); end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] ex_f[4] = '{16'hB000, 16'hB001, 16'hB002, 16'hB003};
    int           ex_c[4] = '{2, 4, 6, 8};
    reset_dut();
    for (int i = 0; i < NR; i++) push(i, ex_f[i], 1'b1);
    repeat (10) tick();
    n_vec++; if (obs_f.size() != 4) begin n_bad++; $display("FAIL rr_count: got %0d want 4", obs_f.size()); end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (k >= obs_f.size()) begin n_bad++; $display("FAIL rr_order%0d: got none want %h@%0d", k, ex_f[k], ex_c[k]); end
      else if (obs_f[k] !== ex_f[k] || obs_c[k] != ex_c[k]) begin
        n_bad++; $display("FAIL rr_order%0d: got %h@%0d want %h@%0d", k, obs_f[k], obs_c[k], ex_f[k], ex_c[k]);
      end
    end
    // Pointer wrapped to 0: requester 0 must beat requester 3.
    start_test();
    push(3, 16'hC003, 1'b1);
    push(0, 16'hC000, 1'b1);
    repeat (6) tick();
    n_vec++;
    if (obs_f.size() != 2) begin n_bad++; $display("FAIL rr_wrap: got %0d flits want 2", obs_f.size()); end
    else if (obs_f[0] !== 16'hC000 || obs_c[0] != 2 || obs_f[1] !== 16'hC003 || obs_c[1] != 4) begin
      n_bad++; $display("FAIL rr_wrap: got %h@%0d %h@%0d want c000@2 c003@4", obs_f[0], obs_c[0], obs_f[1], obs_c[1]);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ex_f[4] = '{16'hD000, 16'hD001, 16'hD002, 16'hD003};
    int           ex_c[4] = '{2, 8, 9, 10};
    start_test();
    for (int k = 0; k < 4; k++) push(2, ex_f[k], k == 3);
    repeat (3) tick();
    ext_ready_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_vec++;
      if (s_ev !== 1'b1 || s_flit !== 16'hD001 || s_ready[2] !== 1'b0) begin
        n_bad++; $display("FAIL bp_stall%0d: got v=%b f=%h rdy=%b want v=1 f=d001 rdy=0", k, s_ev, s_flit, s_ready[2]);
      end
    end
    ext_ready_in = 1'b1;
    repeat (8) tick();
    n_vec++; if (obs_f.size() != 4) begin n_bad++; $display("FAIL bp_count: got %0d want 4", obs_f.size()); end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (k >= obs_f.size()) begin n_bad++; $display("FAIL bp_flit%0d: got none want %h@%0d", k, ex_f[k], ex_c[k]); end
      else if (obs_f[k] !== ex_f[k] || obs_c[k] != ex_c[k]) begin
        n_bad++; $display("FAIL bp_flit%0d: got %h@%0d want %h@%0d", k, obs_f[k], obs_c[k], ex_f[k], ex_c[k]);
      end
    end
  endtask

  task automatic test_no_interleave();
    logic [W-1:0] ex_f[5] = '{16'hE000, 16'hE001, 16'hE002, 16'hE003, 16'hF002};
    int           ex_c[5] = '{2, 3, 4, 5, 7};
    start_test();
    for (int k = 0; k < 4; k++) push(0, ex_f[k], k == 3);
    repeat (2) tick();
    push(2, 16'hF002, 1'b1);
    repeat (8) tick();
    n_vec++; if (obs_f.size() != 5) begin n_bad++; $display("FAIL nil_count: got %0d want 5", obs_f.size()); end
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (k >= obs_f.size()) begin n_bad++; $display("FAIL nil_flit%0d: got none want %h@%0d", k, ex_f[k], ex_c[k]); end
      else if (obs_f[k] !== ex_f[k] || obs_c[k] != ex_c[k]) begin
        n_bad++; $display("FAIL nil_flit%0d: got %h@%0d want %h@%0d", k, obs_f[k], obs_c[k], ex_f[k], ex_c[k]);
      end
    end
  endtask

`ifdef NOC_ARB_WDOG_EN
  task automatic test_watchdog();
    reset_dut();
    push(0, 16'h6000, 1'b0);
    push(0, 16'h6001, 1'b0);
    push(0, 16'h6002, 1'b1);
    push(3, 16'h7003, 1'b1);
    repeat (2) tick();
    hold[0] = 1'b1;
    for (int c = 2; c <= 18; c++) begin
      tick();
      if (c == 17 || c == 18) begin
        n_vec++;
        if (s_abort !== (c == 18)) begin n_bad++; $display("FAIL wdog_pulse_c%0d: got %b want %b", c, s_abort, (c == 18)); end
      end
    end
    hold[0] = 1'b0;
    tick();
    n_vec++; if (s_abort !== 1'b0 || s_ready[0] !== 1'b1) begin n_bad++; $display("FAIL wdog_drop_c19: got abort=%b rdy0=%b want 0 1", s_abort, s_ready[0]); end
    repeat (6) tick();
    n_vec++;
    if (obs_f.size() != 2) begin n_bad++; $display("FAIL wdog_ext: got %0d flits want 2", obs_f.size()); end
    else if (obs_f[0] !== 16'h6000 || obs_c[0] != 2 || obs_f[1] !== 16'h7003 || obs_c[1] != 20) begin
      n_bad++; $display("FAIL wdog_ext: got %h@%0d %h@%0d want 6000@2 7003@20", obs_f[0], obs_c[0], obs_f[1], obs_c[1]);
    end
    n_vec++; if (rq[0].size() != 0) begin n_bad++; $display("FAIL wdog_drained: got %0d left want 0", rq[0].size()); end
  endtask
`else
  task automatic test_hold_no_wdog();
    logic [W-1:0] ex_f[4] = '{16'h6000, 16'h6001, 16'h6002, 16'h7003};
    int           ex_c[4] = '{2, 43, 44, 46};
    int           n_pulse = 0;
    reset_dut();
    push(0, 16'h6000, 1'b0);
    push(0, 16'h6001, 1'b0);
    push(0, 16'h6002, 1'b1);
    push(3, 16'h7003, 1'b1);
    repeat (2) tick();
    hold[0] = 1'b1;
    repeat (40) begin
      tick();
      if (s_abort !== 1'b0) n_pulse++;
    end
    n_vec++; if (n_pulse != 0) begin n_bad++; $display("FAIL hold_abort: got %0d pulses want 0", n_pulse); end
    n_vec++; if (s_busy !== 1'b1 || s_grant !== 2'd0) begin n_bad++; $display("FAIL hold_lock: got busy=%b grant=%0d want 1 0", s_busy, s_grant); end
    hold[0] = 1'b0;
    repeat (10) tick();
    n_vec++; if (obs_f.size() != 4) begin n_bad++; $display("FAIL hold_count: got %0d want 4", obs_f.size()); end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (k >= obs_f.size()) begin n_bad++; $display("FAIL hold_flit%0d: got none want %h@%0d", k, ex_f[k], ex_c[k]); end
      else if (obs_f[k] !== ex_f[k] || obs_c[k] != ex_c[k]) begin
        n_bad++; $display("FAIL hold_flit%0d: got %h@%0d want %h@%0d", k, obs_f[k], obs_c[k], ex_f[k], ex_c[k]);
      end
    end
  endtask
`endif

  task automatic test_reset_mid_packet();
    start_test();
    push(1, 16'h9001, 1'b0);
    push(1, 16'h9002, 1'b0);
    push(1, 16'h9003, 1'b1);
    repeat (3) tick();
    n_vec++; if (s_ev !== 1'b1) begin n_bad++; $display("FAIL mid_pre_valid: got %b want 1", s_ev); end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (ext_valid_out !== 1'b0 || ext_flit_out !== '0 || busy_out !== 1'b0 || grant_id_out !== '0 ||
        req_ready_out !== '0 || wdog_abort_out !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_outs: got v=%b f=%h busy=%b g=%0d rdy=%b ab=%b want all 0",
                        ext_valid_out, ext_flit_out, busy_out, grant_id_out, req_ready_out, wdog_abort_out);
    end
    for (int i = 0; i < NR; i++) rq[i].delete();
    req_valid_in = '0;
    req_last_in  = '0;
    req_flit_in  = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start_test();
    push(2, 16'h8002, 1'b1);
    push(0, 16'h8000, 1'b1);
    repeat (6) tick();
    n_vec++;
    if (obs_f.size() != 2) begin n_bad++; $display("FAIL mid_after: got %0d flits want 2", obs_f.size()); end
    else if (obs_f[0] !== 16'h8000 || obs_c[0] != 2 || obs_f[1] !== 16'h8002 || obs_c[1] != 4) begin
      n_bad++; $display("FAIL mid_after: got %h@%0d %h@%0d want 8000@2 8002@4", obs_f[0], obs_c[0], obs_f[1], obs_c[1]);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_no_interleave();
`ifdef NOC_ARB_WDOG_EN
    test_watchdog();
`else
    test_hold_no_wdog();
`endif
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/noc_ext_arbiter.md
# noc_ext_arbiter

Packet-granular round-robin arbiter that shares the NPU's single external NoC ingress port (`ext_flit_in`/`ext_valid_in`/`ext_ready_out` of the tile-grid top) among several host-side requesters, such as DMA channels and the host command queue. A grant is held from a packet's first flit through the flit marked `last`, so flits from different packets never interleave. A registered output stage drives the mesh boundary. An optional watchdog releases a grant held by a requester that stalls mid-packet.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `NOC_FLIT_WIDTH`, default 64: flit width in bits.
- `WDOG_CYCLES`, default 1024: stall-cycle limit used only with the watchdog compiled in; at least 2.
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req_flit_in` in NUM_REQ*NOC_FLIT_WIDTH: requester flits, requester i at `[i*W +: W]`.
- `req_valid_in` in NUM_REQ: per-requester valid.
- `req_last_in` in NUM_REQ: flit is the last of its packet.
- `req_ready_out` out NUM_REQ: per-requester ready.
- `ext_flit_out` out NOC_FLIT_WIDTH: flit to the mesh external ingress.
- `ext_valid_out` out 1: output flit valid.
- `ext_ready_in` in 1: mesh ready.
- `grant_id_out` out $clog2(NUM_REQ): current or last grant.
- `busy_out` out 1: state is LOCKED.
- `wdog_abort_out` out 1: one-cycle pulse on watchdog release.

## Operation
- **Transfer rule.** A flit transfers on any edge where valid && ready. This applies on both the requester side and the ext side.
- **State machine.** Two states, IDLE and LOCKED. `rr_ptr` resets to 0.
- **IDLE.**
  - If any requester has valid set and its drop flag clear, pick the first one at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - Register that choice as `grant`, set `grant_id_out = grant`, and go to LOCKED.
  - All `req_ready_out` are 0 in IDLE, except requesters with their drop flag set.
- **LOCKED.**
  - `req_ready_out[grant] = !out_vld || ext_ready_in`. All other ready bits are 0, except drop-flagged requesters.
  - Each accepted flit loads the output register (`out_vld` = 1).
  - When the accepted flit has `last` set: go to IDLE and set `rr_ptr = grant + 1` (mod NUM_REQ).
- **Output register.**
  - On an ext transfer with no new load, `out_vld` clears.
  - A load and an ext transfer in the same cycle replace the register contents. No bubble and no duplicate flit.
  - `ext_flit_out` holds stable while `ext_valid_out && !ext_ready_in`.
- **Zero-length/single-flit packets.** A single-flit packet (valid and last together) is legal and is granted like any other.
- **Simultaneous events.** A requester that raises valid in the same cycle as another requester's last-flit transfer competes in the next IDLE cycle.
- **Reset mid-operation.** Asynchronous reset:
  - clears state, `rr_ptr`, drop flags and `out_vld`;
  - discards any partial packet;
  - drives all outputs to 0.

## Timing
- **Reset values.** All outputs are 0.
- **First-flit latency.** Requester valid in cycle 0 → grant registered at edge 1 → flit accepted in cycle 1 → `ext_valid_out` at edge 2.
- **Throughput.** One flit per cycle inside a packet.
- **Packet gap.** One IDLE arbitration cycle between packets, so at most one bubble per packet on the ext side.
- **Watchdog counting.**
  - The stall counter counts LOCKED cycles with `req_valid_in[grant]` = 0.
  - Cycles stalled by `ext_ready_in` = 0 are not counted.
  - The counter clears on every accepted flit.

## Configuration
- **Macro:** `NOC_ARB_WDOG_EN`.
- **With the macro defined:**
  - When the counter reaches WDOG_CYCLES−1 in LOCKED, next edge: pulse `wdog_abort_out`, set `drop[grant]`, go to IDLE, and set `rr_ptr = grant + 1`.
  - A requester with its drop flag set sees `req_ready_out` = 1. Its flits are consumed and discarded.
  - Its drop flag clears when its `last` flit is consumed.
  - It is ineligible for grant while its drop flag is set.
- **Without the macro:** no counter and no drop flags. `wdog_abort_out` is tied 0. A grant is held indefinitely.

## Structure
- **Package `neuraedge_noc_pkg`:** arbiter state enum (IDLE, LOCKED) and the NOC_FLIT_WIDTH default constant, shared with the router code.
- **Sub-module `noc_rr_pick`:** combinational rotate-priority pick.
  - Inputs: request vector, pointer.
  - Outputs: grant index and any-request bit.
  - Reusable by router output arbitration.

## Test plan
1. **Single packet.** Requester 1 sends a 3-flit packet (A1, A2, A3 with last on A3), `ext_ready_in` = 1 → `ext_valid_out` high at edges 2, 3, 4 with A1, A2, A3, and `grant_id_out` = 1.
2. **Round-robin order.** All 4 requesters hold a single-flit packet from reset → output order is 0, 1, 2, 3, each 2 cycles apart; `rr_ptr` ends at 0.
3. **Backpressure.** `ext_ready_in` = 0 for 5 cycles mid-packet → `ext_flit_out` is stable and `req_ready_out[grant]` = 0; after release, all flits arrive exactly once and in order.
4. **No interleave.** Requester 2 raises valid during requester 0's 4-flit packet → requester 2's first flit appears only after requester 0's last flit, plus one bubble.
5. **Watchdog.** With `NOC_ARB_WDOG_EN` and WDOG_CYCLES = 16: requester 0 sends its head flit then drops valid → `wdog_abort_out` pulses 16 cycles later and requester 3's pending packet is granted. Requester 0's remaining flits are dropped, never seen on ext, up to and including its last flit.
6. **Reset mid-packet.** Assert `rst_n` low mid-packet with `ext_valid_out` = 1 → all outputs are 0 immediately. After release, a new packet from requester 0 is granted normally.
